step_sequencer: RTL and testbench

//  Pattern sequencer that plays note events on the synth voice. It holds a table of up to STEPS

---
 rtl/synth_seq_pkg.sv | 24 ++
 rtl/seq_step_table.sv | 40 ++++
 rtl/step_sequencer.sv | 134 +++++++++++++
 tb/tb_step_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_seq_pkg.sv
// Shared types and constants for the note step sequencer.
// The packed step record uses the default pitch-word width of the synth voice.
package synth_seq_pkg;

  localparam int unsigned SEQ_PAW    = 30;
  localparam int unsigned MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic               rest;
    logic [SEQ_PAW-1:0] fccw;
  } seq_step_t;

  // Step length actually used: very short periods are raised to the minimum.
  function automatic logic [31:0] clamp_period(input logic [31:0] period);
    return (period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : period;
  endfunction

endpackage

// File: rtl/seq_step_table.sv
// Step table register file: synchronous write, asynchronous read with write-through
// bypass so a same-cycle write to the address being read is seen immediately.
module seq_step_table #(
  parameter  int PAW   = 30,
  parameter  int STEPS = 16,
  localparam int AW    = $clog2(STEPS)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic           wr_rest,
  input  logic [PAW-1:0] wr_fccw,
  input  logic [AW-1:0]  rd_addr,
  output logic           rd_rest,
  output logic [PAW-1:0] rd_fccw
);

  logic           rest_q [STEPS];
  logic [PAW-1:0] fccw_q [STEPS];
  logic           hit;

  // Empty pattern after reset: every step is a silent rest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STEPS; i++) begin
        rest_q[i] <= 1'b1;
        fccw_q[i] <= '0;
      end
    end else if (wr_en) begin
      rest_q[wr_addr] <= wr_rest;
      fccw_q[wr_addr] <= wr_fccw;
    end
  end

  assign hit     = wr_en && (wr_addr == rd_addr);
  assign rd_rest = hit ? wr_rest : rest_q[rd_addr];
  assign rd_fccw = hit ? wr_fccw : fccw_q[rd_addr];

endmodule

// File: rtl/step_sequencer.sv
// Note step sequencer: walks the step table at a programmable tempo and drives the
// voice pitch word, ADSR gate level and one-shot trigger.
module step_sequencer
  import synth_seq_pkg::*;
#(
  parameter  int PHASE_ACC_WIDTH = 30,
  parameter  int STEPS           = 16,
  localparam int AW              = $clog2(STEPS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic [31:0]                step_period,
  input  logic [31:0]                gate_len,
  input  logic [AW-1:0]              last_step,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic                       wr_rest,
  input  logic [PHASE_ACC_WIDTH-1:0] wr_fccw,
  input  logic                       env_idle,
  output logic [PHASE_ACC_WIDTH-1:0] note_fccw,
  output logic                       gate,
  output logic                       trig,
  output logic [AW-1:0]              cur_step,
  output logic                       busy
);

  seq_state_t                 state;
  logic [31:0]                cnt;
  logic [31:0]                cnt_inc;
  logic [31:0]                per_q;
  logic [31:0]                glen_q;
  logic                       rest_q;
  logic [AW-1:0]              nxt_step;
  logic [AW-1:0]              rd_addr;
  logic                       rd_rest;
  logic [PHASE_ACC_WIDTH-1:0] rd_fccw;
  logic                       step_end;
  logic                       sounding;

  seq_step_table #(
    .PAW   (PHASE_ACC_WIDTH),
    .STEPS (STEPS)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_rest (wr_rest),
    .wr_fccw (wr_fccw),
    .rd_addr (rd_addr),
    .rd_rest (rd_rest),
    .rd_fccw (rd_fccw)
  );

  // A step index beyond last_step (lowered mid-run) also wraps back to 0.
  assign nxt_step = (cur_step >= last_step) ? '0 : cur_step + AW'(1);
  assign rd_addr  = (state == RUN) ? nxt_step : '0;
  assign step_end = (cnt == per_q - 32'd1);
  assign cnt_inc  = cnt + 32'd1;
  assign sounding = !rd_rest && (gate_len != 32'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      per_q     <= 32'(MIN_PERIOD);
      glen_q    <= '0;
      rest_q    <= 1'b1;
      cur_step  <= '0;
      note_fccw <= '0;
      gate      <= 1'b0;
      trig      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gate <= 1'b0;
          trig <= 1'b0;
          busy <= 1'b0;
          if (run) begin
            state     <= RUN;
            busy      <= 1'b1;
            cnt       <= '0;
            cur_step  <= '0;
            note_fccw <= rd_fccw;
            rest_q    <= rd_rest;
            per_q     <= clamp_period(step_period);
            glen_q    <= gate_len;
            gate      <= sounding;
            trig      <= sounding;
          end
        end
        RUN: begin
          if (!run) begin
            // note_fccw is held so the release tail keeps its pitch.
            state <= DRAIN;
            gate  <= 1'b0;
            trig  <= 1'b0;
          end else if (step_end) begin
            // Period and gate length are sampled only here, at the step start.
            cnt       <= '0;
            cur_step  <= nxt_step;
            note_fccw <= rd_fccw;
            rest_q    <= rd_rest;
            per_q     <= clamp_period(step_period);
            glen_q    <= gate_len;
            gate      <= sounding;
            trig      <= sounding;
          end else begin
            cnt  <= cnt_inc;
            gate <= !rest_q && (cnt_inc < glen_q);
            trig <= 1'b0;
          end
        end
        DRAIN: begin
          gate <= 1'b0;
          trig <= 1'b0;
          if (env_idle) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          gate  <= 1'b0;
          trig  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: expected outputs are queued per cycle from a
// closed-form pattern model and compared after each clock edge.
module tb_step_sequencer;

  localparam int PAW = 30;
  localparam int AW  = 4;

  typedef struct packed {
    logic           gate;
    logic           trig;
    logic [PAW-1:0] note;
    logic [AW-1:0]  step;
    logic           busy;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           run;
  logic [31:0]    step_period;
  logic [31:0]    gate_len;
  logic [AW-1:0]  last_step;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic           wr_rest;
  logic [PAW-1:0] wr_fccw;
  logic           env_idle;
  logic [PAW-1:0] note_fccw;
  logic           gate;
  logic           trig;
  logic [AW-1:0]  cur_step;
  logic           busy;

  step_sequencer #(.PHASE_ACC_WIDTH(PAW), .STEPS(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .step_period (step_period),
    .gate_len    (gate_len),
    .last_step   (last_step),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_rest     (wr_rest),
    .wr_fccw     (wr_fccw),
    .env_idle    (env_idle),
    .note_fccw   (note_fccw),
    .gate        (gate),
    .trig        (trig),
    .cur_step    (cur_step),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  localparam logic [PAW-1:0] NA = 30'h0100_0A01;
  localparam logic [PAW-1:0] NB = 30'h0200_0B02;
  localparam logic [PAW-1:0] NC = 30'h0300_0C03;
  localparam logic [PAW-1:0] ND = 30'h0400_0D04;
  localparam logic [PAW-1:0] NE = 30'h0555_0E05;

  int             checks = 0;
  int             errors = 0;
  exp_t           sb[$];
  logic           m_rest [16];
  logic [PAW-1:0] m_fccw [16];

  // Model configuration for the current playback run.
  int             m_per;
  int             m_last;
  int             g_old;
  int             g_new;
  int             n_chg;
  int             wr_cyc;
  int             wr_a;
  logic           wr_r;
  logic [PAW-1:0] wr_f;
  logic [PAW-1:0] last_note;
  logic [AW-1:0]  last_idx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0)
    else begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed gate=%0b expected an entry", tag, gate);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".gate"}, 32'(gate), 32'(e.gate));
      chk({tag, ".trig"}, 32'(trig), 32'(e.trig));
      chk({tag, ".note"}, 32'(note_fccw), 32'(e.note));
      chk({tag, ".step"}, 32'(cur_step), 32'(e.step));
      chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
    end
  endtask

  function automatic exp_t exp_at(input int n);
    exp_t e;
    int   p, s, pos, cur, g;
    p      = (m_per < 2) ? 2 : m_per;
    s      = n / p;
    pos    = n % p;
    cur    = s % (m_last + 1);
    g      = (s * p >= n_chg) ? g_new : g_old;
    e.gate = !m_rest[cur] && (pos < g);
    e.trig = (pos == 0) && !m_rest[cur] && (g != 0);
    e.note = m_fccw[cur];
    e.step = AW'(cur);
    e.busy = 1'b1;
    return e;
  endfunction

  task automatic set_cfg(input int per, input int g, input int last);
    m_per       = per;
    m_last      = last;
    g_old       = g;
    g_new       = g;
    n_chg       = 1 << 30;
    wr_cyc      = -1;
    step_period = 32'(per);
    gate_len    = 32'(g);
    last_step   = AW'(last);
  endtask

  task automatic wr(input int a, input logic r, input logic [PAW-1:0] f);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_rest = r;
    wr_fccw = f;
    tick();
    wr_en     = 1'b0;
    m_rest[a] = r;
    m_fccw[a] = f;
  endtask

  // Edge 0 is the first edge that samples run=1.
  task automatic play(input string tag, input int ncyc);
    exp_t e;
    run = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      e = exp_at(n);
      sb.push_back(e);
      last_note = e.note;
      last_idx  = e.step;
      tick();
      pop_cmp(tag);
      if (n == n_chg - 1) gate_len = 32'(g_new);
      if (n == wr_cyc) begin
        wr_en        = 1'b1;
        wr_addr      = AW'(wr_a);
        wr_rest      = wr_r;
        wr_fccw      = wr_f;
        m_rest[wr_a] = wr_r;
        m_fccw[wr_a] = wr_f;
      end else begin
        wr_en = 1'b0;
      end
    end
  endtask

  task automatic stop_drain(input string tag, input int hold, input bit pulse_run);
    run      = 1'b0;
    env_idle = 1'b0;
    for (int i = 0; i < hold; i++) begin
      sb.push_back('{gate: 1'b0, trig: 1'b0, note: last_note, step: last_idx, busy: 1'b1});
      tick();
      pop_cmp(tag);
      if (pulse_run && i == 1) run = 1'b1;
      if (pulse_run && i == 2) run = 1'b0;
    end
    env_idle = 1'b1;
    sb.push_back('{gate: 1'b0, trig: 1'b0, note: last_note, step: last_idx, busy: 1'b0});
    tick();
    pop_cmp({tag, ".idle"});
    env_idle = 1'b0;
    sb.push_back('{gate: 1'b0, trig: 1'b0, note: last_note, step: last_idx, busy: 1'b0});
    tick();
    pop_cmp({tag, ".idle2"});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_rest[i] = 1'b1;
      m_fccw[i] = '0;
    end
    last_note = '0;
    last_idx  = '0;
  endtask

  initial begin
    reset    = 1'b1;
    run      = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_rest  = 1'b0;
    wr_fccw  = '0;
    env_idle = 1'b0;
    set_cfg(100, 50, 3);
    model_reset();
    #2 reset = 1'b0;
    #1;
    sb.push_back('0);
    pop_cmp("reset");
    @(negedge clk);
    reset = 1'b1;
    tick();

    // 1: four sounding steps, wrap 3 -> 0
    wr(0, 1'b0, NA);
    wr(1, 1'b0, NB);
    wr(2, 1'b0, NC);
    wr(3, 1'b0, ND);
    set_cfg(100, 50, 3);
    play("t1", 401);
    stop_drain("t1.stop", 2, 1'b0);

    // 2: step 1 becomes a rest but keeps its pitch word
    wr(1, 1'b1, NB);
    set_cfg(100, 50, 3);
    play("t2", 401);
    stop_drain("t2.stop", 2, 1'b0);

    // 3: legato, then gate_len dropped to 0 mid-step
    wr(1, 1'b0, NB);
    set_cfg(100, 200, 3);
    g_new = 0;
    n_chg = 250;
    play("t3", 420);
    stop_drain("t3.stop", 2, 1'b0);

    // 4: clamped periods and write-through at step load
    set_cfg(0, 1, 3);
    wr_cyc = 3;
    wr_a   = 2;
    wr_r   = 1'b0;
    wr_f   = NE;
    play("t4.p0", 12);
    stop_drain("t4.p0.stop", 2, 1'b0);
    set_cfg(1, 1, 3);
    play("t4.p1", 9);
    stop_drain("t4.p1.stop", 2, 1'b0);

    // 5: stop at 150, long drain with an ignored run pulse
    set_cfg(100, 50, 3);
    play("t5", 150);
    stop_drain("t5.drain", 250, 1'b1);

    // 6: reset mid-step clears outputs and table
    set_cfg(100, 50, 3);
    play("t6.pre", 37);
    #2;
    reset = 1'b0;
    run   = 1'b0;
    #1;
    model_reset();
    sb.push_back('0);
    pop_cmp("t6.async");
    @(negedge clk);
    reset = 1'b1;
    tick();
    sb.push_back('0);
    pop_cmp("t6.idle");
    play("t6.post", 150);
    stop_drain("t6.stop", 2, 1'b0);

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
